// File: rtl/i2s_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// i2s_tx_serializer: single-buffered stereo PCM to Philips I2S output
// Rev 1.0
// ------------------------------------------------------------------
module i2s_tx_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 16,
  parameter int BCLK_HALF  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  i2s_bclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdata,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int PAD_BITS   = SLOT_BITS - DATA_WIDTH;
  localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int K_W        = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_BITS - 1);
  localparam logic [K_W-1:0]   K_RIGHT  = K_W'(SLOT_BITS);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [K_W-1:0]        k_q, k_d;
  logic                  lrck_q, lrck_d;
  logic                  sdata_q, sdata_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d;
  logic [DATA_WIDTH-1:0] buf_r_q, buf_r_d;
  logic                  underrun_q, underrun_d;

  logic                  w_wrap;
  logic                  w_fall;
  logic                  w_load;
  logic                  w_xfer;
  logic [SLOT_BITS-1:0]  w_slot_l;
  logic [SLOT_BITS-1:0]  w_slot_r;

  assign w_wrap   = (div_q == DIV_LAST);
  assign w_fall   = w_wrap & bclk_q;
  assign w_load   = w_fall & (k_q == '0);
  assign w_xfer   = s_valid & ~full_q;
  // Samples sit in the top of their slot; the low pad bits shift in as zero.
  assign w_slot_l = SLOT_BITS'(buf_l_q) << PAD_BITS;
  assign w_slot_r = SLOT_BITS'(buf_r_q) << PAD_BITS;

  always_comb begin
    div_d      = w_wrap ? '0 : div_q + 1'b1;
    bclk_d     = bclk_q ^ w_wrap;
    k_d        = k_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    frame_d    = frame_q;
    full_d     = full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    underrun_d = 1'b0;

    if (w_fall) begin
      k_d     = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      lrck_d  = (k_q >= K_RIGHT);
      // The MSB still holds the previous bit, giving the one-BCLK I2S delay.
      sdata_d = frame_q[FRAME_BITS-1];
      frame_d = frame_q << 1;
      if (w_load) begin
        frame_d    = full_q ? {w_slot_l, w_slot_r} : '0;
        full_d     = 1'b0;
        underrun_d = ~full_q;
      end
    end

    if (w_xfer) begin
      full_d  = 1'b1;
      buf_l_d = s_left;
      buf_r_d = s_right;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      k_q        <= '0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      frame_q    <= '0;
      full_q     <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      k_q        <= k_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      frame_q    <= frame_d;
      full_q     <= full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready   = ~full_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_i2s_tx_serializer: directed bench with a cycle-count I2S model
// Rev 1.0
// ------------------------------------------------------------------
module tb_i2s_tx_serializer;

  localparam int DW     = 16;
  localparam int SB     = 16;
  localparam int BH     = 2;
  localparam int FW     = 2 * SB;
  localparam int PERIOD = FW * 2 * BH;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          s_valid = 1'b0;
  wire           s_ready, bclk, lrck, sdata, und;

  logic [15:0]   l24 = '0;
  logic [15:0]   r24 = '0;
  logic          v24 = 1'b0;
  wire           rdy24, bclk24, lrck24, sdata24, und24;

  always #5 clk = ~clk;

  i2s_tx_serializer #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .BCLK_HALF(BH)) u_dut (
    .clk(clk), .resetn(resetn), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(s_ready), .i2s_bclk(bclk), .i2s_lrck(lrck),
    .i2s_sdata(sdata), .underrun(und)
  );

  i2s_tx_serializer #(.DATA_WIDTH(16), .SLOT_BITS(24), .BCLK_HALF(2)) u_dut24 (
    .clk(clk), .resetn(resetn), .s_left(l24), .s_right(r24),
    .s_valid(v24), .s_ready(rdy24), .i2s_bclk(bclk24), .i2s_lrck(lrck24),
    .i2s_sdata(sdata24), .underrun(und24)
  );

  int total = 0;
  int bad   = 0;

  // Model: n = clk edges since reset release; everything else follows from n
  // plus the list of frames chosen at each frame start.
  int            n = 0;
  logic          m_full = 1'b0;
  logic [DW-1:0] m_l = '0;
  logic [DW-1:0] m_r = '0;
  logic [FW-1:0] m_frames[$];
  logic [4:0]    exp_vec = 5'b00010;

  function automatic logic [FW-1:0] mk_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [FW-1:0] fr;
    fr = '0;
    fr[FW-1 -: DW] = l;
    fr[SB-1 -: DW] = r;
    return fr;
  endfunction

  always @(posedge clk) begin : model
    int f, g;
    logic full0, load, mu, e_lr, e_sd;
    if (!resetn) begin
      n = 0;
      m_full = 1'b0;
      m_frames.delete();
      exp_vec = 5'b00010;
    end else begin
      n = n + 1;
      full0 = m_full;
      load = (n % (2*BH) == 0) && ((((n / (2*BH)) - 1) % FW) == 0);
      mu = load && !full0;
      if (load) begin
        m_frames.push_back(full0 ? mk_frame(m_l, m_r) : '0);
        m_full = 1'b0;
      end
      if (s_valid && !full0) begin
        m_full = 1'b1;
        m_l = s_left;
        m_r = s_right;
      end
      f = n / (2*BH);
      e_lr = (f == 0) ? 1'b0 : (((f - 1) % FW) >= SB);
      g = f - 2;
      e_sd = 1'b0;
      if (g >= 0) e_sd = m_frames[g / FW][FW - 1 - (g % FW)];
      exp_vec = {(((n / BH) % 2) == 1), e_lr, e_sd, !m_full, mu};
    end
  end

  int xfer_cnt = 0;
  int rdy_cnt  = 0;
  int und_cnt  = 0;

  always @(posedge clk) begin
    if (resetn) begin
      if (s_valid && s_ready) xfer_cnt <= xfer_cnt + 1;
      if (s_ready) rdy_cnt <= rdy_cnt + 1;
      if (und) und_cnt <= und_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic bclk_rise(input int sel);
    logic prev, cur, hit;
    prev = (sel != 0) ? bclk24 : bclk;
    hit = 1'b0;
    for (int t = 0; t < 32 && !hit; t++) begin
      @(negedge clk);
      cur = (sel != 0) ? bclk24 : bclk;
      hit = !prev && cur;
      prev = cur;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL bclk_rise_timeout got=no_edge want=edge");
    end
  endtask

  task automatic grab(input int sel, input int skip, input int nb, output logic [63:0] w);
    w = '0;
    for (int i = 0; i < skip; i++) bclk_rise(sel);
    for (int i = 0; i < nb; i++) begin
      bclk_rise(sel);
      w = {w[62:0], ((sel != 0) ? sdata24 : sdata)};
    end
  endtask

  task automatic lrck24_rise(output int cycles);
    logic prev, hit;
    prev = lrck24;
    hit = 1'b0;
    cycles = 0;
    while (!hit && cycles < 400) begin
      @(negedge clk);
      cycles++;
      hit = !prev && lrck24;
      prev = lrck24;
    end
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int t;
    t = 0;
    @(negedge clk);
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    while (!s_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=ready_low want=ready_high");
    end
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one rising edge; outputs must clear without a clock.
  task automatic rst_pulse();
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk("async_reset", {bclk, lrck, sdata, s_ready, und}, 64'h02);
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    logic [63:0] w;
    int u0, x0, r0, t, sent;
    logic [4:0] got;

    fork
      forever begin
        @(negedge clk);
        if (resetn) begin
          got = {bclk, lrck, sdata, s_ready, und};
          total++;
          if (got !== exp_vec) begin
            bad++;
            $display("FAIL model n=%0d got=%b want=%b", n, got, exp_vec);
          end
        end
      end
    join_none

    @(negedge clk);
    chk("reset_state", {bclk, lrck, sdata, s_ready, und}, 64'h02);
    chk("reset_state24", {bclk24, lrck24, sdata24, rdy24, und24}, 64'h02);
    @(negedge clk);
    #2 resetn = 1'b1;

    // Idle: one underrun per frame, zero data.
    u0 = und_cnt;
    repeat (3 * PERIOD) @(negedge clk);
    chk("idle_underruns", 64'(und_cnt - u0), 64'd3);

    // Pair present before the first frame start.
    rst_pulse();
    u0 = und_cnt;
    s_left = 16'hA5C3;
    s_right = 16'h8001;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    grab(0, 2, 32, w);
    chk("frame_a5c3_8001", w[31:0], 64'hA5C38001);
    chk("first_frames_underruns", 64'(und_cnt - u0), 64'd1);

    // Continuous streaming of counting pairs.
    sent = 0;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          send(16'(2 * i), 16'(2 * i + 1));
          sent++;
        end
        s_valid = 1'b0;
      end
      begin
        t = 0;
        while (sent < 2 && t < 1000) begin
          @(negedge clk);
          t++;
        end
        x0 = xfer_cnt;
        r0 = rdy_cnt;
        u0 = und_cnt;
        repeat (4 * PERIOD) @(negedge clk);
        chk("stream_transfers", 64'(xfer_cnt - x0), 64'd4);
        chk("stream_ready_cycles", 64'(rdy_cnt - r0), 64'd4);
        chk("stream_underruns", 64'(und_cnt - u0), 64'd0);
      end
    join

    // Transfer on the same edge as a frame start with the buffer empty.
    t = 0;
    while (!(!m_full && (n % PERIOD) == 3) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("align_wait", 64'(t < 2000), 64'd1);
    s_left = 16'h1234;
    s_right = 16'hBEEF;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    chk("coincident_underrun", 64'(und), 64'd1);
    chk("coincident_ready", 64'(s_ready), 64'd0);
    grab(0, 1, 32, w);
    chk("coincident_zero_frame", w[31:0], 64'h0);
    grab(0, 0, 32, w);
    chk("coincident_next_frame", w[31:0], 64'h1234BEEF);

    // Reset while a pair is held: the pair is lost.
    send(16'hCAFE, 16'hF00D);
    s_valid = 1'b0;
    repeat (37) @(negedge clk);
    rst_pulse();
    u0 = und_cnt;
    grab(0, 2, 32, w);
    chk("reset_drops_pair", w[31:0], 64'h0);
    chk("reset_underruns", 64'(und_cnt - u0), 64'd2);

    // 24-bit slots carrying 16-bit samples.
    rst_pulse();
    l24 = 16'hFFFF;
    r24 = 16'h0000;
    v24 = 1'b1;
    @(posedge clk);
    #1 v24 = 1'b0;
    grab(1, 2, 24, w);
    chk("slot24_left", w[23:0], 64'hFFFF00);
    lrck24_rise(t);
    lrck24_rise(t);
    chk("lrck24_period_clks", 64'(t), 64'd192);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
